// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_pkg
//  Description : Shared types and constants for the RV32 immediate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_Z = 3'b101
    } imm_src_e;

endpackage
`default_nettype wire

// File: rtl/imm_gen_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_decode
//  Description : Combinational RV32 immediate extraction and extension.
//                IMM_GEN_ZIMM_EN enables the CSR zimm format on code 101.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_decode
    import imm_gen_pkg::*;
(
    input  logic [31:7]     inst,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_comb,
    output logic            illegal_comb
);

    always_comb begin
        imm_comb     = '0;
        illegal_comb = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I: imm_comb = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imm_comb = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imm_comb = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm_comb = {inst[31:12], 12'b0};
            IMM_J: imm_comb = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_Z: imm_comb = {27'b0, inst[19:15]};
`endif
            // Reserved codes yield a defined zero immediate plus the flag.
            default: illegal_comb = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Registered RV32 immediate generator (1-cycle latency) with
//                valid and illegal-format flags. Honours IMM_GEN_ZIMM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:7]     inst,
    input  logic [2:0]      imm_src,
    input  logic            in_valid,
    output logic [XLEN-1:0] imm_ext,
    output logic            out_valid,
    output logic            illegal_src
);

    logic [XLEN-1:0] w_immComb;
    logic            w_illegalComb;
    logic [XLEN-1:0] r_immExt;
    logic            r_outValid;
    logic            r_illegal;

    imm_gen_decode u_decode (
        .inst         (inst),
        .imm_src      (imm_src),
        .imm_comb     (w_immComb),
        .illegal_comb (w_illegalComb)
    );

    // Result and flag only update on accepted inputs; valid tracks every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_immExt   <= '0;
            r_outValid <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_immExt  <= w_immComb;
                r_illegal <= w_illegalComb;
            end
        end
    end

    assign imm_ext     = r_immExt;
    assign out_valid   = r_outValid;
    assign illegal_src = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen
//  Description : Self-checking bench for imm_gen: directed vector table,
//                reset sequences and randomized traffic against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen;

    logic        clk;
    logic        rst_n;
    logic [31:7] inst;
    logic [2:0]  imm_src;
    logic        in_valid;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        illegal_src;

    int errors = 0;
    int checks = 0;

    imm_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst        (inst),
        .imm_src     (imm_src),
        .in_valid    (in_valid),
        .imm_ext     (imm_ext),
        .out_valid   (out_valid),
        .illegal_src (illegal_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] vInst;
        logic [2:0]  vSrc;
        logic        vVld;
        logic [31:0] expImm;
        logic        expVal;
        logic        expIll;
    } vec_t;

    // Reference: rebuild the full instruction word and assemble the value
    // arithmetically from the field weights of each format.
    function automatic void refModel(input logic [24:0] i, input logic [2:0] s,
                                     output logic [31:0] imm, output logic ill);
        logic [31:0] w;
        int sw;
        int r;
        w   = {i, 7'b0};
        sw  = int'(w);
        r   = 0;
        ill = 1'b0;
        case (s)
            3'd0: r = sw >>> 20;
            3'd1: r = (sw >>> 25) * 32 + int'(w[11:7]);
            3'd2: r = (sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
            3'd3: r = int'(w & 32'hFFFFF000);
            3'd4: r = (sw >>> 31) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
`ifdef IMM_GEN_ZIMM_EN
            3'd5: r = int'(w[19:15]);
`endif
            default: ill = 1'b1;
        endcase
        imm = r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] eImm, input logic eVal, input logic eIll);
        check({tag, ".imm"}, imm_ext, eImm);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, eVal});
        check({tag, ".illegal"}, {31'b0, illegal_src}, {31'b0, eIll});
    endtask

    task automatic drive(input logic [24:0] i, input logic [2:0] s, input logic v);
        inst     = i;
        imm_src  = s;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[12];
    logic [31:0] mImm;
    logic        mIll;
    logic [31:0] tImm;
    logic        tIll;
    logic [24:0] rInst;
    logic [2:0]  rSrc;
    logic        rVld;

    initial begin
        vecs[0]  = '{25'b0000001101100101110101001, 3'b000, 1'b1, 32'd54,         1'b1, 1'b0};
        vecs[1]  = '{25'b0000001110110101110110110, 3'b001, 1'b1, 32'd54,         1'b1, 1'b0};
        vecs[2]  = '{25'b0000001110110101110110110, 3'b010, 1'b1, 32'd54,         1'b1, 1'b0};
        vecs[3]  = '{25'b0000000000000011011001001, 3'b011, 1'b1, 32'h00036000,   1'b1, 1'b0};
        vecs[4]  = '{25'b0000001101100000000001001, 3'b100, 1'b1, 32'd54,         1'b1, 1'b0};
        vecs[5]  = '{{12'hFFF, 13'b0},              3'b000, 1'b1, 32'hFFFFFFFF,   1'b1, 1'b0};
        vecs[6]  = '{{1'b1, 24'b0},                 3'b010, 1'b1, 32'hFFFFF000,   1'b1, 1'b0};
        vecs[7]  = '{25'h1ABCDEF,                   3'b111, 1'b1, 32'd0,          1'b1, 1'b1};
        vecs[8]  = '{25'h0123456,                   3'b000, 1'b0, 32'd0,          1'b0, 1'b1};
        vecs[9]  = '{25'b0000001101100101110101001, 3'b000, 1'b1, 32'd54,         1'b1, 1'b0};
        vecs[10] = '{25'h1FFFFFF,                   3'b110, 1'b0, 32'd54,         1'b0, 1'b0};
`ifdef IMM_GEN_ZIMM_EN
        vecs[11] = '{25'b10110 << 8,                3'b101, 1'b1, 32'd22,         1'b1, 1'b0};
`else
        vecs[11] = '{25'b10110 << 8,                3'b101, 1'b1, 32'd0,          1'b1, 1'b1};
`endif

        rst_n    = 1'b0;
        inst     = '0;
        imm_src  = '0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkAll("reset", 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            drive(vecs[k].vInst, vecs[k].vSrc, vecs[k].vVld);
            checkAll($sformatf("vec%0d", k), vecs[k].expImm, vecs[k].expVal, vecs[k].expIll);
        end

        // Reset asserted while a valid input is presented must win.
        drive(25'h1ABCDEF, 3'b111, 1'b1);
        checkAll("preRst", 32'd0, 1'b1, 1'b1);
        rst_n = 1'b0;
        drive(25'b0000001101100101110101001, 3'b000, 1'b1);
        checkAll("midRst", 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(25'b0000001101100101110101001, 3'b000, 1'b1);
        checkAll("postRst", 32'd54, 1'b1, 1'b0);
        drive(25'b0, 3'b000, 1'b0);
        checkAll("postRstIdle", 32'd54, 1'b0, 1'b0);

        mImm = 32'd54;
        mIll = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rInst = 25'($urandom);
            rSrc  = 3'($urandom_range(0, 7));
            rVld  = ($urandom_range(0, 3) != 0);
            if (rVld) begin
                refModel(rInst, rSrc, tImm, tIll);
                mImm = tImm;
                mIll = tIll;
            end
            drive(rInst, rSrc, rVld);
            checkAll($sformatf("rnd%0d", n), mImm, rVld, mIll);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
